seg7_hex_writer: RTL

Upstream feeder for the Sandpiper 7-segment driver (PGL_Sandpiper_vAlpha_7Seg_Driver). Takes a 32-bit value plus display attributes and converts it to eight hex characters. Writes the characters one at a time into the driver's character buffer using the driver's `commit_char` write port. Optional leading-zero blanking, per-digit decimal points and a buffer-clear request.

---
 rtl/seg7_hex_writer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/seg7_hex_writer.sv
// seg7_hex_writer: converts a captured 32-bit value into eight hex glyphs
// and writes them one by one into the 7-segment driver's character buffer.
// Strobes and status outputs are registered from the current state, so they
// trail the FSM by one cycle; clear_buffer is registered from the next state
// so it lines up exactly with the CLEAR cycle.
module seg7_hex_writer #(
  parameter int COMMIT_CYC = 2,
  parameter int GAP_CYC    = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] value,
  input  logic [7:0]  brightness,
  input  logic [7:0]  dp_mask,
  input  logic        blank_lz,
  output logic [7:0]  SEGMENTS_2_LIGHT,
  output logic [2:0]  CHAR_SELECTED,
  output logic [7:0]  CHAR_BRIGHTNESS,
  output logic        commit_char,
  output logic        clear_buffer,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SETUP, S_COMMIT, S_GAP, S_DONE
  } state_t;

  localparam logic [15:0] COMMIT_LAST = 16'(COMMIT_CYC - 1);
  localparam logic [15:0] GAP_LAST    = 16'(GAP_CYC - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic [2:0]  digit;
  logic        load_pend;
  logic [31:0] cap_value;
  logic [7:0]  cap_bright;
  logic [7:0]  cap_dp;
  logic        cap_blank;
  logic [7:0]  upper_zero;
  logic [3:0]  nib;
  logic [7:0]  seg_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  // Next-state logic; load/clear only matter in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (clear)     state_nxt = S_CLEAR;
        else if (load) state_nxt = S_SETUP;
      end
      S_CLEAR:  state_nxt = load_pend ? S_SETUP : S_IDLE;
      S_SETUP:  state_nxt = S_COMMIT;
      S_COMMIT: if (cnt == COMMIT_LAST) state_nxt = S_GAP;
      S_GAP: begin
        if (cnt == GAP_LAST) state_nxt = (digit == 3'd7) ? S_DONE : S_SETUP;
      end
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Glyph for the current digit; a digit is a leading zero when every
  // nibble from it upward is zero, digit 0 always shows
  always_comb begin
    for (int i = 0; i < 8; i++)
      upper_zero[i] = ((cap_value >> (4 * i)) == 32'd0);
    nib     = cap_value[{digit, 2'b00} +: 4];
    seg_nxt = {cap_dp[digit], hex7(nib)};
    if (cap_blank && digit != 3'd0 && upper_zero[digit])
      seg_nxt[6:0] = 7'h00;
  end

  // State, dwell counter, digit index and attribute capture
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      digit      <= '0;
      load_pend  <= 1'b0;
      cap_value  <= '0;
      cap_bright <= '0;
      cap_dp     <= '0;
      cap_blank  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state) ? 16'd0 : cnt + 16'd1;
      if (state == S_IDLE) begin
        digit     <= '0;
        load_pend <= load;
        if (load) begin
          cap_value  <= value;
          cap_bright <= brightness;
          cap_dp     <= dp_mask;
          cap_blank  <= blank_lz;
        end
      end else if (state == S_GAP && state_nxt == S_SETUP) begin
        digit <= digit + 3'd1;
      end
    end
  end

  // Registered driver-facing outputs
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      SEGMENTS_2_LIGHT <= '0;
      CHAR_SELECTED    <= '0;
      CHAR_BRIGHTNESS  <= '0;
      commit_char      <= 1'b0;
      clear_buffer     <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      if (state == S_SETUP) begin
        SEGMENTS_2_LIGHT <= seg_nxt;
        CHAR_SELECTED    <= digit;
        CHAR_BRIGHTNESS  <= cap_bright;
      end
      commit_char  <= (state == S_COMMIT);
      clear_buffer <= (state_nxt == S_CLEAR);
      busy         <= (state != S_IDLE) && (state != S_DONE);
      done         <= (state == S_DONE);
    end
  end

endmodule
